// File: rtl/light_ctrl_pkg.sv
// light_ctrl_pkg: channel state encoding and the counter-width helper shared
// by the PIR/LDR light controller and its per-channel slice.
package light_ctrl_pkg;

   localparam logic [1:0] ST_OFF    = 2'd0;
   localparam logic [1:0] ST_IDLE   = 2'd1;
   localparam logic [1:0] ST_ACTIVE = 2'd2;
   localparam logic [1:0] ST_HOLD   = 2'd3;

   typedef enum logic [1:0] {
      S_OFF    = ST_OFF,
      S_IDLE   = ST_IDLE,
      S_ACTIVE = ST_ACTIVE,
      S_HOLD   = ST_HOLD
   } chan_state_t;

   // Bits needed to hold values 0..n-1; never less than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/light_ctrl_chan.sv
// light_ctrl_chan: one PIR/LDR channel -- sensor synchronisers, the
// OFF/IDLE/ACTIVE/HOLD state machine, the hold-off counter and the
// registered LED / hold outputs.
module light_ctrl_chan
   import light_ctrl_pkg::*;
#(
   parameter int HOLD_CYCLES = 1000,
   parameter int SYNC_STAGES = 2
) (
   input  logic hclk,
   input  logic rst_n,
   input  logic en,
   input  logic pwm_hi,
   input  logic pir_in,
   input  logic ldr_in,
   output logic led_out,
   output logic hold_o
);

   localparam int              HW        = cnt_width(HOLD_CYCLES);
   localparam logic [HW-1:0]   HOLD_LOAD = HW'(HOLD_CYCLES - 1);

   logic [SYNC_STAGES-1:0] pir_sync;
   logic [SYNC_STAGES-1:0] ldr_sync;
   logic                   pir_s;
   logic                   ldr_s;
   logic                   live;
   chan_state_t            state_reg;
   chan_state_t            state_next;
   logic [HW-1:0]          hold_reg;
   logic [HW-1:0]          hold_next;
   logic                   led_next;

   assign pir_s = pir_sync[SYNC_STAGES-1];
   assign ldr_s = ldr_sync[SYNC_STAGES-1];
   // A channel may light only when globally enabled and the room is dark.
   assign live  = en & ldr_s;

   // Shift-register synchronisers for the asynchronous sensor pins.
   always_ff @(posedge hclk or negedge rst_n) begin
      if (!rst_n) begin
         pir_sync <= '0;
         ldr_sync <= '0;
      end else begin
         pir_sync <= {pir_sync[SYNC_STAGES-2:0], pir_in};
         ldr_sync <= {ldr_sync[SYNC_STAGES-2:0], ldr_in};
      end
   end

   // Next state and hold counter; losing darkness/enable wins over motion,
   // and motion wins over hold expiry.
   always_comb begin
      state_next = state_reg;
      hold_next  = hold_reg;
      case (state_reg)
         S_OFF: begin
            if (live) state_next = pir_s ? S_ACTIVE : S_IDLE;
         end
         S_IDLE: begin
            if (!live)      state_next = S_OFF;
            else if (pir_s) state_next = S_ACTIVE;
         end
         S_ACTIVE: begin
            if (!live) begin
               state_next = S_OFF;
            end else if (!pir_s) begin
               state_next = S_HOLD;
               hold_next  = HOLD_LOAD;
            end
         end
         S_HOLD: begin
            if (!live) begin
               state_next = S_OFF;
               hold_next  = '0;
            end else if (pir_s) begin
               state_next = S_ACTIVE;
               hold_next  = '0;
            end else if (hold_reg == '0) begin
               state_next = S_IDLE;
            end else begin
               hold_next  = hold_reg - HW'(1);
            end
         end
         default: begin
            state_next = S_OFF;
            hold_next  = '0;
         end
      endcase
   end

   // LED drive decoded from the current state: full on, idle dim, or dark.
   always_comb begin
      led_next = 1'b0;
      if (state_reg == S_ACTIVE || state_reg == S_HOLD) led_next = 1'b1;
      else if (state_reg == S_IDLE)                     led_next = pwm_hi;
   end

   // State, counter and output registers.
   always_ff @(posedge hclk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_OFF;
         hold_reg  <= '0;
         led_out   <= 1'b0;
         hold_o    <= 1'b0;
      end else begin
         state_reg <= state_next;
         hold_reg  <= hold_next;
         led_out   <= led_next;
         hold_o    <= (state_reg == S_HOLD);
      end
   end

endmodule

// File: rtl/pir_ldr_light_ctrl.sv
// pir_ldr_light_ctrl: multi-channel occupancy / ambient-light LED controller.
// Holds the shared PWM timebase so every idle channel dims in phase, and one
// light_ctrl_chan per channel.
module pir_ldr_light_ctrl
   import light_ctrl_pkg::*;
#(
   parameter int CHANNELS    = 1,
   parameter int PWM_PERIOD  = 100,
   parameter int IDLE_DUTY   = 20,
   parameter int HOLD_CYCLES = 1000,
   parameter int SYNC_STAGES = 2
) (
   input  logic                hclk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [CHANNELS-1:0] pir_in,
   input  logic [CHANNELS-1:0] LDR_in,
   output logic [CHANNELS-1:0] led_out,
   output logic [CHANNELS-1:0] hold_o
);

   localparam int            PW       = cnt_width(PWM_PERIOD);
   localparam logic [PW-1:0] PWM_LAST = PW'(PWM_PERIOD - 1);

   logic [PW-1:0] pwm_cnt;
   logic          pwm_hi;

   if (CHANNELS < 1) begin : g_bad_channels
      $error("CHANNELS must be at least 1");
   end
   if (PWM_PERIOD < 1) begin : g_bad_period
      $error("PWM_PERIOD must be at least 1");
   end
   if (IDLE_DUTY < 0 || IDLE_DUTY > PWM_PERIOD) begin : g_bad_duty
      $error("IDLE_DUTY must lie in 0..PWM_PERIOD");
   end
   if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("HOLD_CYCLES must be at least 1");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
   end

   // Free-running PWM timebase, 0..PWM_PERIOD-1.
   always_ff @(posedge hclk or negedge rst_n) begin
      if (!rst_n)                  pwm_cnt <= '0;
      else if (pwm_cnt == PWM_LAST) pwm_cnt <= '0;
      else                         pwm_cnt <= pwm_cnt + PW'(1);
   end

   // Duty 0 never matches; duty PWM_PERIOD always matches.
   assign pwm_hi = (32'(pwm_cnt) < IDLE_DUTY);

   genvar gi;
   for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      light_ctrl_chan #(
         .HOLD_CYCLES (HOLD_CYCLES),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
         .hclk    (hclk),
         .rst_n   (rst_n),
         .en      (en),
         .pwm_hi  (pwm_hi),
         .pir_in  (pir_in[gi]),
         .ldr_in  (LDR_in[gi]),
         .led_out (led_out[gi]),
         .hold_o  (hold_o[gi])
      );
   end

endmodule
